matrix_operand_loader: RTL and testbench
========================================

# matrix_operand_loader

Upstream stage of the element-wise matrix ALU. Accepts a byte stream of operand elements over a valid/ready handshake, fills operand matrices A and B in row-major order, and presents both as flattened buses with a valid/ready handshake to the subtraction/ALU stage. Supports an active size from 1x1 to TAMANHO x TAMANHO. Elements outside the active size read as zero.

## Interface
- TAMANHO, 5: maximum matrix dimension (square); legal range 1..7.
- WIDTH, 8: element width in bits.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current load.
- cfg_size  in  3  active dimension; sampled on the first accepted A element.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  loader can accept an element (registered).
- in_data  in  WIDTH  element value, unsigned.
- mat_a  out  TAMANHO*TAMANHO*WIDTH  element (i,j) at bits [(i*TAMANHO+j)*WIDTH +: WIDTH].
- mat_b  out  TAMANHO*TAMANHO*WIDTH  same layout as mat_a.
- act_size  out  3  latched active dimension for the downstream stage.
- out_valid  out  1  both matrices complete and stable (registered).
- out_ready  in  1  downstream consumes the pair.

## Operation
- States: LOAD_A, LOAD_B, FULL. Row counter `row` and column counter `col` run 0..act_size-1.
- Transfer: an element is transferred on an edge where in_valid && in_ready. No other condition stores data.
- First A transfer (LOAD_A, row=col=0):
  - Latch act_size = cfg_size, clamped as follows: 0 becomes 1; values above TAMANHO become TAMANHO.
  - Clear every element of both banks to 0.
  - Write in_data to A(0,0). Clearing and writing happen on the same edge.
- Each transfer writes in_data to (row,col) of the current bank, then advances:
  - col increments.
  - When col = act_size-1, col goes to 0 and row increments.
  - When row = col = act_size-1, row and col both go to 0 and the state advances (LOAD_A to LOAD_B; LOAD_B to FULL).
- act_size latches only on the first A transfer. It is reported unchanged until the next first-A transfer.
- FULL:
  - in_ready=0 and out_valid=1. mat_a, mat_b and act_size are held stable.
  - On an edge with out_ready=1: go to LOAD_A, out_valid=0, in_ready=1.
  - Bank contents remain visible until the next first-A transfer clears them.
- flush=1 on an edge (any state):
  - Go to LOAD_A; row=col=0; out_valid=0; in_ready=1.
  - Banks and act_size keep their values.
  - flush takes priority over a simultaneous transfer (the element is dropped) and over a simultaneous out_ready.
- The loader performs no arithmetic. Data is stored unmodified. in_data is a full WIDTH-bit value; no wrap or saturation is applied.

## Timing
- Reset (rst_n=0, asynchronous): state=LOAD_A, row=col=0, in_ready=0, out_valid=0, act_size=TAMANHO, mat_a=0, mat_b=0.
- First rising edge after rst_n deasserts: in_ready becomes 1. No transfer is possible on that edge.
- Throughput: one element per cycle while in_valid is held high. A full load takes 2*act_size^2 transfers.
- Latency: the last B element is accepted on edge N. On edge N, in_ready falls and out_valid rises; both are visible in cycle N+1.
- Consume: out_valid && out_ready on edge M. From edge M, out_valid=0 and in_ready=1, so a new A element can transfer on edge M+1.
  - Minimum gap between pairs: 1 cycle (the FULL cycle).
- in_valid while in_ready=0: no effect. Upstream must hold in_data until the transfer occurs.
- Reset mid-load: everything returns immediately to the reset values. Partial data is discarded.
- The downstream stage may sample mat_a/mat_b at any cycle while out_valid=1. The buses do not change until after the consuming edge.

## Test plan
- Reset, then cfg_size=5; stream 1..25 into A and 26..50 into B back-to-back.
  - Required: out_valid rises exactly 50 transfers after the first; A(0,0)=1, A(4,4)=25, B(2,3)=39; act_size=5.
- cfg_size=2; stream A=4,4,4,4 and B=4,4,4,4.
  - Required: A(0,0..1) and A(1,0..1) are 4; every other element of A and B is 0; act_size=2.
- cfg_size=0, then cfg_size=7 (with TAMANHO=5).
  - Required: act_size=1 after 2 transfers; act_size=5 after 50 transfers.
- Hold out_ready=0 for 10 cycles in FULL while in_valid=1.
  - Required: in_ready=0 and buses stable throughout. Raise out_ready: out_valid falls, and the next element lands in A(0,0) with both banks cleared.
- Assert flush after 30 transfers, on the same edge as a transfer.
  - Required: the element is dropped, state=LOAD_A, out_valid stays 0. The next 50 transfers produce a complete pair.
- Assert rst_n=0 mid-B-load, asynchronously between edges.
  - Required: outputs are zero immediately; in_ready=0 until the first edge after release, then 1.

Source files
------------

// File: rtl/matrix_operand_loader.sv
// Operand loader for the element-wise matrix ALU: fills banks A and B from a
// row-major byte stream and hands the completed pair downstream.
module matrix_operand_loader #(
   parameter int TAMANHO = 5,
   parameter int WIDTH   = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                flush,
   input  logic [2:0]                          cfg_size,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [WIDTH-1:0]                    in_data,
   output logic [TAMANHO*TAMANHO*WIDTH-1:0]    mat_a,
   output logic [TAMANHO*TAMANHO*WIDTH-1:0]    mat_b,
   output logic [2:0]                          act_size,
   output logic                                out_valid,
   input  logic                                out_ready
);

   localparam int         BUS_W    = TAMANHO * TAMANHO * WIDTH;
   localparam logic [2:0] MAX_SIZE = 3'(TAMANHO);

   typedef enum logic [1:0] {
      LOAD_A,
      LOAD_B,
      FULL
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [2:0]         r_row;
   logic [2:0]         r_col;
   logic [2:0]         w_next_row;
   logic [2:0]         w_next_col;
   logic [2:0]         r_act_size;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [BUS_W-1:0]   r_mat_a;
   logic [BUS_W-1:0]   r_mat_b;

   logic               w_xfer;
   logic               w_first;
   logic               w_store;
   logic [2:0]         w_cfg_clamped;
   logic [2:0]         w_size;
   logic               w_last_col;
   logic               w_last_row;
   logic [5:0]         w_idx;

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign act_size  = r_act_size;
   assign mat_a     = r_mat_a;
   assign mat_b     = r_mat_b;

   assign w_xfer  = in_valid && r_in_ready;
   assign w_first = w_xfer && (r_state == LOAD_A) && (r_row == 3'd0) && (r_col == 3'd0);
   // flush wins over a coincident transfer: the element is dropped.
   assign w_store = w_xfer && !flush;

   assign w_cfg_clamped = (cfg_size == 3'd0)    ? 3'd1     :
                          (cfg_size > MAX_SIZE) ? MAX_SIZE : cfg_size;
   // The first A element must already walk with the newly sampled size.
   assign w_size     = w_first ? w_cfg_clamped : r_act_size;
   assign w_last_col = (r_col == w_size - 3'd1);
   assign w_last_row = (r_row == w_size - 3'd1);
   assign w_idx      = 6'(r_row) * 6'(TAMANHO) + 6'(r_col);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_next_state = r_state;
      w_next_row   = r_row;
      w_next_col   = r_col;
      if (flush) begin
         w_next_state = LOAD_A;
         w_next_row   = 3'd0;
         w_next_col   = 3'd0;
      end else begin
         case (r_state)
            LOAD_A, LOAD_B: begin
               if (w_xfer) begin
                  if (w_last_col) begin
                     w_next_col = 3'd0;
                     if (w_last_row) begin
                        w_next_row   = 3'd0;
                        w_next_state = (r_state == LOAD_A) ? LOAD_B : FULL;
                     end else begin
                        w_next_row = r_row + 3'd1;
                     end
                  end else begin
                     w_next_col = r_col + 3'd1;
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  w_next_state = LOAD_A;
               end
            end
            default: begin
               w_next_state = LOAD_A;
               w_next_row   = 3'd0;
               w_next_col   = 3'd0;
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= LOAD_A;
         r_row       <= 3'd0;
         r_col       <= 3'd0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_act_size  <= MAX_SIZE;
      end else begin
         r_state     <= w_next_state;
         r_row       <= w_next_row;
         r_col       <= w_next_col;
         r_in_ready  <= (w_next_state != FULL);
         r_out_valid <= (w_next_state == FULL);
         if (w_first && !flush) begin
            r_act_size <= w_cfg_clamped;
         end
      end
   end

   // NOTE: the banks are architecturally visible after reset, so unlike a plain RAM they are reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mat_a <= '0;
         r_mat_b <= '0;
      end else if (w_store) begin
         // The clear and the first write share an edge; the later write wins.
         if (w_first) begin
            r_mat_a <= '0;
            r_mat_b <= '0;
         end
         if (r_state == LOAD_A) begin
            r_mat_a[w_idx*WIDTH +: WIDTH] <= in_data;
         end else if (r_state == LOAD_B) begin
            r_mat_b[w_idx*WIDTH +: WIDTH] <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: load/hand-off, clamping, hold in
// FULL, flush and asynchronous reset, with hand-computed expectations.
module tb_matrix_operand_loader;

   localparam int T   = 5;
   localparam int W   = 8;
   localparam int BUS = T * T * W;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flush;
   logic [2:0]     cfg_size;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic [BUS-1:0] mat_a;
   logic [BUS-1:0] mat_b;
   logic [2:0]     act_size;
   logic           out_valid;
   logic           out_ready;

   int total = 0;
   int bad   = 0;
   int stall = 0;

   matrix_operand_loader #(.TAMANHO(T), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .cfg_size  (cfg_size),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .mat_a     (mat_a),
      .mat_b     (mat_b),
      .act_size  (act_size),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] el(input logic [BUS-1:0] m, input int i, input int j);
      return m[(i*T+j)*W +: W];
   endfunction

   function automatic logic [BUS-1:0] put(input logic [BUS-1:0] m, input int i, input int j,
                                          input logic [7:0] v);
      m[(i*T+j)*W +: W] = v;
      return m;
   endfunction

   // One element transfer; leaves in_valid high so consecutive calls stream back-to-back.
   task automatic push(input logic [7:0] v);
      int guard = 0;
      in_valid = 1'b1;
      in_data  = v;
      while (in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
         stall++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL push_ready_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL consume: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; cfg_size = 3'd5; out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'd99;
      #12;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
      end
      total++;
      if (act_size !== 3'd5) begin
         bad++;
         $display("FAIL reset_act: act_size=%0d required 5", act_size);
      end
      total++;
      if (mat_a !== '0 || mat_b !== '0) begin
         bad++;
         $display("FAIL reset_banks: mat_a=%h mat_b=%h required 0", mat_a, mat_b);
      end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || mat_a !== '0) begin
         bad++;
         $display("FAIL reset_first_edge: in_ready=%b mat_a=%h required 1 0", in_ready, mat_a);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full_load();
      cfg_size = 3'd5;
      stall = 0;
      push(8'd1);
      cfg_size = 3'd2;  // ignored once the first A element is in
      for (int k = 2; k <= 49; k++) push(8'(k));
      total++;
      if (out_valid !== 1'b0 || stall != 0) begin
         bad++;
         $display("FAIL full_49: out_valid=%b stalls=%0d required 0 0", out_valid, stall);
      end
      push(8'd50);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_50: out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
      end
      total++;
      if (el(mat_a,0,0) !== 8'd1 || el(mat_a,4,4) !== 8'd25 || el(mat_b,2,3) !== 8'd39) begin
         bad++;
         $display("FAIL full_data: A00=%0d A44=%0d B23=%0d required 1 25 39",
                  el(mat_a,0,0), el(mat_a,4,4), el(mat_b,2,3));
      end
      total++;
      if (act_size !== 3'd5) begin
         bad++;
         $display("FAIL full_act: act_size=%0d required 5", act_size);
      end
      consume();
      total++;
      if (el(mat_a,0,0) !== 8'd1) begin
         bad++;
         $display("FAIL full_visible: A00=%0d required 1", el(mat_a,0,0));
      end
   endtask

   task automatic test_small_size();
      logic [BUS-1:0] exp_m;
      exp_m = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            exp_m = put(exp_m, i, j, 8'd4);
      cfg_size = 3'd2;
      for (int k = 0; k < 8; k++) push(8'd4);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || act_size !== 3'd2) begin
         bad++;
         $display("FAIL small_done: out_valid=%b act_size=%0d required 1 2", out_valid, act_size);
      end
      total++;
      if (mat_a !== exp_m || mat_b !== exp_m) begin
         bad++;
         $display("FAIL small_banks: mat_a=%h mat_b=%h required %h", mat_a, mat_b, exp_m);
      end
   endtask

   task automatic test_hold_full();
      logic [BUS-1:0] sa, sb, exp_a;
      sa = mat_a;
      sb = mat_b;
      in_valid = 1'b1; in_data = 8'd77; out_ready = 1'b0; cfg_size = 3'd5;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         total++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || mat_a !== sa || mat_b !== sb) begin
            bad++;
            $display("FAIL hold_cycle%0d: in_ready=%b out_valid=%b stable=%b required 0 1 1",
                     c, in_ready, out_valid, (mat_a === sa) && (mat_b === sb));
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || mat_a !== sa) begin
         bad++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b kept=%b required 0 1 1",
                  out_valid, in_ready, mat_a === sa);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_a = put('0, 0, 0, 8'd77);
      total++;
      if (mat_a !== exp_a || mat_b !== '0 || act_size !== 3'd5) begin
         bad++;
         $display("FAIL hold_next: mat_a=%h mat_b=%h act=%0d required %h 0 5",
                  mat_a, mat_b, act_size, exp_a);
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || el(mat_a,0,0) !== 8'd77) begin
         bad++;
         $display("FAIL hold_flush: in_ready=%b out_valid=%b A00=%0d required 1 0 77",
                  in_ready, out_valid, el(mat_a,0,0));
      end
   endtask

   task automatic test_clamp();
      cfg_size = 3'd0;
      push(8'd5);
      push(8'd6);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || act_size !== 3'd1) begin
         bad++;
         $display("FAIL clamp0: out_valid=%b act_size=%0d required 1 1", out_valid, act_size);
      end
      total++;
      if (mat_a !== put('0, 0, 0, 8'd5) || mat_b !== put('0, 0, 0, 8'd6)) begin
         bad++;
         $display("FAIL clamp0_banks: mat_a=%h mat_b=%h", mat_a, mat_b);
      end
      consume();
      cfg_size = 3'd7;
      for (int k = 0; k < 49; k++) push(8'(100 + k));
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL clamp7_49: out_valid=%b required 0", out_valid);
      end
      push(8'd149);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || act_size !== 3'd5) begin
         bad++;
         $display("FAIL clamp7: out_valid=%b act_size=%0d required 1 5", out_valid, act_size);
      end
      total++;
      if (el(mat_a,0,0) !== 8'd100 || el(mat_a,4,4) !== 8'd124 || el(mat_b,4,4) !== 8'd149) begin
         bad++;
         $display("FAIL clamp7_data: A00=%0d A44=%0d B44=%0d required 100 124 149",
                  el(mat_a,0,0), el(mat_a,4,4), el(mat_b,4,4));
      end
      consume();
   endtask

   task automatic test_flush();
      cfg_size = 3'd5;
      for (int k = 1; k <= 29; k++) push(8'(k));
      in_data = 8'd200;
      flush   = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL flush_hs: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      total++;
      if (el(mat_b,0,4) !== 8'd0 || el(mat_b,0,3) !== 8'd29 || el(mat_a,4,4) !== 8'd25
          || act_size !== 3'd5) begin
         bad++;
         $display("FAIL flush_keep: B04=%0d B03=%0d A44=%0d act=%0d required 0 29 25 5",
                  el(mat_b,0,4), el(mat_b,0,3), el(mat_a,4,4), act_size);
      end
      for (int k = 51; k <= 99; k++) push(8'(k));
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_reload49: out_valid=%b required 0", out_valid);
      end
      push(8'd100);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || el(mat_a,0,0) !== 8'd51 || el(mat_b,0,4) !== 8'd80
          || el(mat_b,4,4) !== 8'd100) begin
         bad++;
         $display("FAIL flush_reload: out_valid=%b A00=%0d B04=%0d B44=%0d required 1 51 80 100",
                  out_valid, el(mat_a,0,0), el(mat_b,0,4), el(mat_b,4,4));
      end
      consume();
   endtask

   task automatic test_reset_mid();
      cfg_size = 3'd3;
      for (int k = 1; k <= 13; k++) push(8'(k));
      in_valid = 1'b0;
      total++;
      if (act_size !== 3'd3 || el(mat_b,1,0) !== 8'd13) begin
         bad++;
         $display("FAIL rmid_pre: act=%0d B10=%0d required 3 13", act_size, el(mat_b,1,0));
      end
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || mat_a !== '0 || mat_b !== '0
          || act_size !== 3'd5) begin
         bad++;
         $display("FAIL rmid_async: in_ready=%b out_valid=%b act=%0d zero=%b required 0 0 5 1",
                  in_ready, out_valid, act_size, (mat_a === '0) && (mat_b === '0));
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL rmid_release: in_ready=%b required 0", in_ready);
      end
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rmid_edge: in_ready=%b required 1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_small_size();
      test_hold_full();
      test_clamp();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
